// File: rtl/pipe_buf_reg_pkg.sv
// Shared definitions for the pipelined RV core buffers and its load/run sequencer.
//   ctrl_state_e : states of the load/run sequencer
//   BEAT_BYTES   : address step per load beat (two 32-bit words)
package Pipe_Buf_Reg_PKG;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } ctrl_state_e;

    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/pipe_load_run_ctrl_load_ptr.sv
// load_ptr: byte-address pointer that advances one load beat (BEAT_BYTES) per inc.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : synchronous return to address 0
//   inc         : advance by BEAT_BYTES, modulo 2^DM_ADDRESS
//   ptr         : current pointer value
//   wrap        : high in the cycle an inc carries the pointer past the top back to 0
module load_ptr
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [DM_ADDRESS-1:0] ptr,
    output logic                  wrap
);

    // One extra bit catches the carry out of the top of the address space.
    logic [DM_ADDRESS:0] sum;

    assign sum  = {1'b0, ptr} + (DM_ADDRESS+1)'(BEAT_BYTES);
    assign wrap = inc & sum[DM_ADDRESS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= sum[DM_ADDRESS-1:0];
        end
    end

endmodule

// File: rtl/pipe_load_run_ctrl.sv
// pipe_load_run_ctrl: sequencer that loads the core's instruction and data
// memories from a host beat stream, then releases the core to run until a
// store to HALT_ADDR or until run_limit cycles have elapsed.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   start                    : begin a load (honoured in IDLE and DONE only)
//   run_limit                : RUN cycle budget, 0 = unlimited
//   ld_valid/ld_ready        : host beat handshake; a beat moves when both are high
//                              on a rising edge; ld_ready is high only in LOAD
//   ld_sel, ld_last          : target memory (0 inst, 1 data), final beat marker
//   ld_data0/ld_data1        : low/high word of the beat
//   enable_load_ex_mem       : datapath init/hold enable
//   InstExMem*/DataExMem*    : memory-init address and words
//   wr, addr                 : datapath MEM-stage store strobe and address
//   busy, done, timeout      : status flags
//   overflow                 : sticky, a load pointer wrapped
//   cycle_count              : RUN cycles, saturating
//   state_dbg                : current sequencer state
module pipe_load_run_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int                    DM_ADDRESS = 9,
    parameter int                    DATA_W     = 32,
    parameter int                    CNT_W      = 16,
    parameter logic [DM_ADDRESS-1:0] HALT_ADDR  = 9'h1F8,
    parameter int                    DRAIN_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      run_limit,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic                  ld_last,
    input  logic [DATA_W-1:0]     ld_data0,
    input  logic [DATA_W-1:0]     ld_data1,
    output logic                  enable_load_ex_mem,
    output logic [DM_ADDRESS-1:0] InstExMemAddress,
    output logic [DATA_W-1:0]     InstExMemData1,
    output logic [DATA_W-1:0]     InstExMemData2,
    output logic [DM_ADDRESS-1:0] DataExMemAddress,
    output logic [DATA_W-1:0]     DataExMemData1,
    output logic [DATA_W-1:0]     DataExMemData2,
    input  logic                  wr,
    input  logic [DM_ADDRESS-1:0] addr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic [CNT_W-1:0]      cycle_count,
    output ctrl_state_e           state_dbg
);

    localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRW-1:0] DRAIN_LAST = DRW'(DRAIN_CYC - 1);

    ctrl_state_e           state, state_next;
    logic [DRW-1:0]        drain_cnt;
    logic                  beat, halt, limit_hit;
    logic                  ptr_clear, inst_inc, data_inc;
    logic [DM_ADDRESS-1:0] inst_ptr, data_ptr;
    logic                  inst_wrap, data_wrap;

    load_ptr #(.DM_ADDRESS(DM_ADDRESS)) u_inst_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (ptr_clear),
        .inc   (inst_inc),
        .ptr   (inst_ptr),
        .wrap  (inst_wrap)
    );

    load_ptr #(.DM_ADDRESS(DM_ADDRESS)) u_data_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (ptr_clear),
        .inc   (data_inc),
        .ptr   (data_ptr),
        .wrap  (data_wrap)
    );

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        ptr_clear  = 1'b0;
        inst_inc   = 1'b0;
        data_inc   = 1'b0;
        beat       = ld_valid && ld_ready;
        halt       = wr && (addr == HALT_ADDR);
        // Compared one bit wider so a saturated count never aliases to a small limit.
        limit_hit  = (run_limit != '0) &&
                     (({1'b0, cycle_count} + (CNT_W+1)'(1)) == {1'b0, run_limit});
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                    ptr_clear  = 1'b1;
                end
            end
            LOAD: begin
                if (beat) begin
                    inst_inc = !ld_sel;
                    data_inc = ld_sel;
                    if (ld_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_next = RUN;
            end
            RUN: begin
                if (halt || limit_hit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Flags are derived from the next state so every output is registered and
    // stays aligned with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            drain_cnt          <= '0;
            enable_load_ex_mem <= 1'b1;
            ld_ready           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout            <= 1'b0;
            overflow           <= 1'b0;
            cycle_count        <= '0;
            InstExMemAddress   <= '0;
            InstExMemData1     <= '0;
            InstExMemData2     <= '0;
            DataExMemAddress   <= '0;
            DataExMemData1     <= '0;
            DataExMemData2     <= '0;
        end else begin
            state              <= state_next;
            enable_load_ex_mem <= (state_next == IDLE) || (state_next == LOAD) ||
                                  (state_next == DRAIN);
            ld_ready           <= (state_next == LOAD);
            busy               <= (state_next == LOAD) || (state_next == DRAIN) ||
                                  (state_next == RUN);
            done               <= (state_next == DONE);

            drain_cnt <= (state == DRAIN) ? drain_cnt + DRW'(1) : '0;

            if (ptr_clear) begin
                overflow    <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
            end

            if (inst_inc) begin
                InstExMemAddress <= inst_ptr;
                InstExMemData1   <= ld_data0;
                InstExMemData2   <= ld_data1;
            end
            if (data_inc) begin
                DataExMemAddress <= data_ptr;
                DataExMemData1   <= ld_data0;
                DataExMemData2   <= ld_data1;
            end
            if (inst_wrap || data_wrap) overflow <= 1'b1;

            if (state == RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                // A halt in the same cycle as the limit is a clean halt.
                if (!halt && limit_hit) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_load_run_ctrl.sv
module tb_pipe_load_run_ctrl;
  import Pipe_Buf_Reg_PKG::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] run_limit = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_sel = 1'b0;
  logic        ld_last = 1'b0;
  logic [31:0] ld_data0 = '0;
  logic [31:0] ld_data1 = '0;
  logic        enable_load_ex_mem;
  logic [8:0]  InstExMemAddress;
  logic [31:0] InstExMemData1, InstExMemData2;
  logic [8:0]  DataExMemAddress;
  logic [31:0] DataExMemData1, DataExMemData2;
  logic        wr = 1'b0;
  logic [8:0]  addr = '0;
  logic        busy, done, timeout, overflow;
  logic [15:0] cycle_count;
  ctrl_state_e state_dbg;

  pipe_load_run_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .run_limit          (run_limit),
    .ld_valid           (ld_valid),
    .ld_ready           (ld_ready),
    .ld_sel             (ld_sel),
    .ld_last            (ld_last),
    .ld_data0           (ld_data0),
    .ld_data1           (ld_data1),
    .enable_load_ex_mem (enable_load_ex_mem),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .wr                 (wr),
    .addr               (addr),
    .busy               (busy),
    .done               (done),
    .timeout            (timeout),
    .overflow           (overflow),
    .cycle_count        (cycle_count),
    .state_dbg          (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;
  int hs_count = 0;

  // {sel, addr, data0, data1}
  logic [73:0] exp_q[$];
  logic [72:0] last_port[2];

  typedef struct {
    logic        sel;
    logic        last;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [8:0]  exp_addr;
  } beat_t;

  beat_t tbl[4];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat moves on the edge where ld_valid && ld_ready; compare
  // both init ports one step later against the expected port contents.
  always @(posedge clk) begin
    logic        hs;
    logic [73:0] e;
    hs = reset && ld_valid && ld_ready;
    #1;
    if (!reset) begin
      last_port[0] = '0;
      last_port[1] = '0;
    end else if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: handshake with empty queue (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        last_port[e[73]] = e[72:0];
        check("inst_port", {InstExMemAddress, InstExMemData1, InstExMemData2}, last_port[0]);
        check("data_port", {DataExMemAddress, DataExMemData1, DataExMemData2}, last_port[1]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Random idle gaps before each beat give a toggling ld_valid.
  task automatic send_beat(input logic sel, input logic last, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [8:0] exp_addr);
    int budget;
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_last  = last;
    ld_data0 = d0;
    ld_data1 = d1;
    budget   = 20;
    while (!ld_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ld_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ld_ready_wait: got 0 expected 1 within 20 cycles");
    end else begin
      exp_q.push_back({sel, exp_addr, d0, d1});
      n_push++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("done_wait", 80'(done), 80'(1));
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0013, 9'd0};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0013, 9'd8};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0013, 9'd16};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_DEAD, 32'h0000_BEEF, 9'd0};

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_enable",   80'(enable_load_ex_mem), 80'(1));
    check("rst_ld_ready", 80'(ld_ready), 80'(0));
    check("rst_flags",    80'({busy, done, timeout, overflow}), 80'(0));
    check("rst_count",    80'(cycle_count), 80'(0));
    check("rst_addrs",    80'({InstExMemAddress, DataExMemAddress}), 80'(0));
    check("rst_state",    80'(state_dbg), 80'(IDLE));

    // reset asserted in the middle of a load
    pulse_start();
    check("load_state", 80'(state_dbg), 80'(LOAD));
    send_beat(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 9'd0);
    send_beat(1'b0, 1'b0, 32'h3333_3333, 32'h4444_4444, 9'd8);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_enable",   80'(enable_load_ex_mem), 80'(1));
    check("midrst_ld_ready", 80'(ld_ready), 80'(0));
    check("midrst_addrs",    80'({InstExMemAddress, DataExMemAddress}), 80'(0));
    check("midrst_idata",    80'({InstExMemData1, InstExMemData2}), 80'(0));
    check("midrst_state",    80'(state_dbg), 80'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();

    // table-driven load: 3 inst beats, 1 data beat with ld_last
    run_limit = '0;
    pulse_start();
    for (int i = 0; i < 4; i++)
      send_beat(tbl[i].sel, tbl[i].last, tbl[i].d0, tbl[i].d1, tbl[i].exp_addr);
    check("drain1_enable", 80'(enable_load_ex_mem), 80'(1));
    check("drain1_ready",  80'(ld_ready), 80'(0));
    check("drain1_state",  80'(state_dbg), 80'(DRAIN));
    @(negedge clk);
    check("drain2_enable", 80'(enable_load_ex_mem), 80'(1));
    @(negedge clk);
    check("run_enable",    80'(enable_load_ex_mem), 80'(0));
    check("run_busy",      80'(busy), 80'(1));
    check("run_state",     80'(state_dbg), 80'(RUN));
    check("run_count0",    80'(cycle_count), 80'(0));
    check("hold_inst",     80'(InstExMemAddress), 80'(16));

    // halt at run cycle 5; start and ld_valid are driven but must be ignored
    ld_valid = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 2);
      wr    = (k == 3) || (k == 5);
      addr  = (k == 5) ? 9'h1F8 : 9'h1F0;
    end
    @(negedge clk);
    wr = 1'b0;
    start = 1'b0;
    ld_valid = 1'b0;
    check("halt_done",    80'(done), 80'(1));
    check("halt_timeout", 80'(timeout), 80'(0));
    check("halt_count",   80'(cycle_count), 80'(5));
    check("halt_busy",    80'({busy, enable_load_ex_mem}), 80'(0));
    check("halt_state",   80'(state_dbg), 80'(DONE));
    check("hold_data",    80'({DataExMemData1, DataExMemData2}), 80'({32'h0000_DEAD, 32'h0000_BEEF}));

    // start in DONE reloads; then run to the cycle budget
    run_limit = 16'd10;
    pulse_start();
    check("reload_done",  80'(done), 80'(0));
    check("reload_state", 80'(state_dbg), 80'(LOAD));
    check("reload_count", 80'(cycle_count), 80'(0));
    send_beat(1'b1, 1'b1, $urandom, $urandom, 9'd0);
    wait_done(60);
    check("limit_timeout", 80'(timeout), 80'(1));
    check("limit_count",   80'(cycle_count), 80'(10));

    // halt and limit in the same cycle: halt wins
    run_limit = 16'd4;
    pulse_start();
    send_beat(1'b0, 1'b1, $urandom, $urandom, 9'd0);
    @(negedge clk);            // drain cycle 2
    @(negedge clk);            // run cycle 1
    repeat (3) @(negedge clk); // run cycle 4
    wr = 1'b1;
    addr = 9'h1F8;
    @(negedge clk);
    wr = 1'b0;
    check("both_done",    80'(done), 80'(1));
    check("both_timeout", 80'(timeout), 80'(0));
    check("both_count",   80'(cycle_count), 80'(4));

    // 65 inst beats: pointer wraps, overflow sticks
    run_limit = 16'd3;
    pulse_start();
    for (int i = 0; i < 65; i++) begin
      send_beat(1'b0, i == 64, $urandom, $urandom, 9'(i * 8));
      if (i == 62) check("ovf_before_wrap", 80'(overflow), 80'(0));
      if (i == 63) check("ovf_at_wrap", 80'(overflow), 80'(1));
    end
    check("ovf_final",      80'(overflow), 80'(1));
    check("wrap_inst_addr", 80'(InstExMemAddress), 80'(0));
    wait_done(40);
    check("handshakes", 80'(hs_count), 80'(n_push));
    check("queue_empty", 80'(exp_q.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
